// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word and the cache controller state encoding.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } cache_ctrl_state_t;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: f = sel ? b : a.
module mux2 #(
  parameter int unsigned width = 32
) (
  input  logic             sel,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] f
);

  assign f = sel ? b : a;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way, 8-set, 32-byte-line cache: hit handling,
// dirty-victim writeback and line allocation against physical memory.
module cache_control
  import rv32i_types::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_tag    = 32 - s_offset - s_index
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_word        mem_address,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit_control,
  input  logic             dirty_bit,
  input  logic [s_tag-1:0] tag_array_out,
  output logic             data_read,
  output logic             tag_read,
  output logic             valid_read,
  output logic             dirty_read,
  output logic             lru_read,
  output logic             data_write,
  output logic             force_data_write,
  output logic             force_data_read,
  output logic             lru_load,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic             dirty_load_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output rv32i_word        pmem_address
);

  cache_ctrl_state_t state_q, state_d;
  rv32i_word         line_address;
  rv32i_word         victim_address;
  logic              req;

  assign req            = mem_read | mem_write;
  assign line_address   = {mem_address[31:s_offset], {s_offset{1'b0}}};
  assign victim_address = {tag_array_out, mem_address[s_offset+s_index-1:s_offset],
                           {s_offset{1'b0}}};

  mux2 #(
    .width(32)
  ) u_pmem_address_mux (
    .sel(state_q == WRITEBACK),
    .a  (line_address),
    .b  (victim_address),
    .f  (pmem_address)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    data_read        = 1'b1;
    tag_read         = 1'b1;
    valid_read       = 1'b1;
    dirty_read       = 1'b1;
    lru_read         = 1'b1;
    mem_resp         = 1'b0;
    data_write       = 1'b0;
    force_data_write = 1'b0;
    force_data_read  = 1'b0;
    lru_load         = 1'b0;
    tag_load         = 1'b0;
    valid_load       = 1'b0;
    dirty_load       = 1'b0;
    dirty_in         = 1'b0;
    dirty_load_sel   = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) state_d = CHECK;
      end
      CHECK: begin
        // A request withdrawn during a miss falls back to IDLE silently.
        if (!req) begin
          state_d = IDLE;
        end else if (hit_control) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          state_d  = IDLE;
          // Simultaneous read and write resolves as a write.
          if (mem_write) begin
            data_write     = 1'b1;
            dirty_load     = 1'b1;
            dirty_in       = 1'b1;
            dirty_load_sel = 1'b0;
          end
        end else if (dirty_bit) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write      = 1'b1;
        force_data_read = 1'b1;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          force_data_write = 1'b1;
          tag_load         = 1'b1;
          valid_load       = 1'b1;
          dirty_load       = 1'b1;
          dirty_in         = 1'b0;
          dirty_load_sel   = 1'b1;
          state_d          = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed, table-driven bench for cache_control: one vector per clock cycle,
// plus hand-written reset, withdrawal and back-to-back sequences.
module tb_cache_control;

  localparam logic [11:0] S_RESP = 12'h800;
  localparam logic [11:0] S_DW   = 12'h400;
  localparam logic [11:0] S_FDW  = 12'h200;
  localparam logic [11:0] S_FDR  = 12'h100;
  localparam logic [11:0] S_LRU  = 12'h080;
  localparam logic [11:0] S_TAG  = 12'h040;
  localparam logic [11:0] S_VAL  = 12'h020;
  localparam logic [11:0] S_DL   = 12'h010;
  localparam logic [11:0] S_DIN  = 12'h008;
  localparam logic [11:0] S_DSEL = 12'h004;
  localparam logic [11:0] S_PR   = 12'h002;
  localparam logic [11:0] S_PW   = 12'h001;

  localparam logic [11:0] HIT_RD = S_RESP | S_LRU;
  localparam logic [11:0] HIT_WR = S_RESP | S_LRU | S_DW | S_DL | S_DIN;
  localparam logic [11:0] FILL   = S_PR | S_FDW | S_TAG | S_VAL | S_DL | S_DSEL;
  localparam logic [11:0] WB     = S_PW | S_FDR;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        hit;
    logic        dirty;
    logic [23:0] tag;
    logic        presp;
    logic [11:0] strb;
    logic [31:0] paddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read, mem_write, mem_resp;
  logic        hit_control, dirty_bit;
  logic [23:0] tag_array_out;
  logic        data_read, tag_read, valid_read, dirty_read, lru_read;
  logic        data_write, force_data_write, force_data_read;
  logic        lru_load, tag_load, valid_load, dirty_load, dirty_in, dirty_load_sel;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int resp_last = -1;
  int resp_prev = -1;
  vec_t tbl[26];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_resp === 1'b1) begin
      resp_prev = resp_last;
      resp_last = cyc;
    end
  end

  cache_control dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_resp        (mem_resp),
    .hit_control     (hit_control),
    .dirty_bit       (dirty_bit),
    .tag_array_out   (tag_array_out),
    .data_read       (data_read),
    .tag_read        (tag_read),
    .valid_read      (valid_read),
    .dirty_read      (dirty_read),
    .lru_read        (lru_read),
    .data_write      (data_write),
    .force_data_write(force_data_write),
    .force_data_read (force_data_read),
    .lru_load        (lru_load),
    .tag_load        (tag_load),
    .valid_load      (valid_load),
    .dirty_load      (dirty_load),
    .dirty_in        (dirty_in),
    .dirty_load_sel  (dirty_load_sel),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp),
    .pmem_address    (pmem_address)
  );

  function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic hit, input logic dirty,
                              input logic [23:0] tag, input logic presp,
                              input logic [11:0] strb, input logic [31:0] paddr);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = addr; v.hit = hit; v.dirty = dirty;
    v.tag = tag; v.presp = presp; v.strb = strb; v.paddr = paddr;
    return v;
  endfunction

  // Drive one cycle of inputs, compare at the falling edge, advance past the next rise.
  task automatic run_vec(input vec_t v, input string name);
    logic [11:0] act;
    logic [4:0]  rds;
    rst = v.rst; mem_read = v.rd; mem_write = v.wr; mem_address = v.addr;
    hit_control = v.hit; dirty_bit = v.dirty; tag_array_out = v.tag; pmem_resp = v.presp;
    @(negedge clk);
    act = {mem_resp, data_write, force_data_write, force_data_read, lru_load, tag_load,
           valid_load, dirty_load, dirty_in, dirty_load_sel, pmem_read, pmem_write};
    rds = {data_read, tag_read, valid_read, dirty_read, lru_read};
    checks++;
    if (act !== v.strb || pmem_address !== v.paddr || rds !== 5'h1f) begin
      errors++;
      $display("FAIL %s: strobes=%h paddr=%h reads=%b, required strobes=%h paddr=%h reads=11111",
               name, act, pmem_address, rds, v.strb, v.paddr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 0, 32'h40, 0, 0, 0, 0, 12'h0, 32'h40);
    tbl[1]  = mk(0, 1, 0, 32'h40, 1, 0, 0, 0, HIT_RD, 32'h40);
    tbl[2]  = mk(0, 0, 0, 32'h40, 0, 0, 0, 0, 12'h0, 32'h40);
    tbl[3]  = mk(0, 0, 1, 32'h44, 0, 0, 0, 0, 12'h0, 32'h40);
    tbl[4]  = mk(0, 0, 1, 32'h44, 1, 0, 0, 0, HIT_WR, 32'h40);
    tbl[5]  = mk(0, 0, 0, 32'h44, 0, 0, 0, 0, 12'h0, 32'h40);
    tbl[6]  = mk(0, 1, 0, 32'h1234_5660, 0, 0, 0, 0, 12'h0, 32'h1234_5660);
    tbl[7]  = mk(0, 1, 0, 32'h1234_5660, 0, 0, 0, 0, 12'h0, 32'h1234_5660);
    for (int i = 8; i < 12; i++) tbl[i] = mk(0, 1, 0, 32'h1234_5660, 0, 0, 0, 0, S_PR,
                                             32'h1234_5660);
    tbl[12] = mk(0, 1, 0, 32'h1234_5660, 0, 0, 0, 1, FILL, 32'h1234_5660);
    tbl[13] = mk(0, 1, 0, 32'h1234_5660, 1, 0, 0, 0, HIT_RD, 32'h1234_5660);
    tbl[14] = mk(0, 0, 0, 32'h1234_5660, 0, 0, 0, 0, 12'h0, 32'h1234_5660);
    tbl[15] = mk(0, 1, 0, 32'h10A0, 0, 1, 24'hABCD, 0, 12'h0, 32'h10A0);
    tbl[16] = mk(0, 1, 0, 32'h10A0, 0, 1, 24'hABCD, 0, 12'h0, 32'h10A0);
    tbl[17] = mk(0, 1, 0, 32'h10A0, 0, 1, 24'hABCD, 0, WB, 32'h00AB_CDA0);
    tbl[18] = mk(0, 1, 0, 32'h10A0, 0, 1, 24'hABCD, 1, WB, 32'h00AB_CDA0);
    tbl[19] = mk(0, 1, 0, 32'h10A0, 0, 1, 24'hABCD, 1, FILL, 32'h10A0);
    tbl[20] = mk(0, 1, 0, 32'h10A0, 1, 0, 24'hABCD, 0, HIT_RD, 32'h10A0);
    tbl[21] = mk(0, 0, 0, 32'h10A0, 0, 0, 0, 0, 12'h0, 32'h10A0);
    tbl[22] = mk(0, 0, 0, 32'h10A0, 0, 0, 0, 1, 12'h0, 32'h10A0);
    tbl[23] = mk(0, 1, 1, 32'h80, 1, 0, 0, 0, 12'h0, 32'h80);
    tbl[24] = mk(0, 1, 1, 32'h80, 1, 0, 0, 0, HIT_WR, 32'h80);
    tbl[25] = mk(0, 0, 0, 32'h80, 0, 0, 0, 0, 12'h0, 32'h80);

    #1;
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_address = 0;
    hit_control = 0; dirty_bit = 0; tag_array_out = 0; pmem_resp = 0;
    @(posedge clk);
    #1;
    run_vec(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 12'h0, 32'h0), "reset");

    for (int i = 0; i < 26; i++) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // Reset while allocating; a late pmem_resp must be ignored afterwards.
    run_vec(mk(0, 1, 0, 32'h200, 0, 0, 0, 0, 12'h0, 32'h200), "rst_alloc_idle");
    run_vec(mk(0, 1, 0, 32'h200, 0, 0, 0, 0, 12'h0, 32'h200), "rst_alloc_check");
    run_vec(mk(0, 1, 0, 32'h200, 0, 0, 0, 0, S_PR, 32'h200), "rst_alloc_pr");
    run_vec(mk(1, 1, 0, 32'h200, 0, 0, 0, 0, S_PR, 32'h200), "rst_alloc_rst");
    run_vec(mk(0, 0, 0, 32'h200, 0, 0, 0, 1, 12'h0, 32'h200), "rst_alloc_stray");
    run_vec(mk(0, 1, 0, 32'h200, 1, 0, 0, 0, 12'h0, 32'h200), "rst_alloc_is_idle");
    run_vec(mk(0, 1, 0, 32'h200, 1, 0, 0, 0, HIT_RD, 32'h200), "rst_alloc_hit");

    // Request withdrawn mid-miss: fill completes, CHECK exits with no mem_resp.
    run_vec(mk(0, 1, 0, 32'h300, 0, 0, 0, 0, 12'h0, 32'h300), "drop_idle");
    run_vec(mk(0, 1, 0, 32'h300, 0, 0, 0, 0, 12'h0, 32'h300), "drop_check");
    run_vec(mk(0, 0, 0, 32'h300, 0, 0, 0, 1, FILL, 32'h300), "drop_fill");
    run_vec(mk(0, 0, 0, 32'h300, 1, 0, 0, 0, 12'h0, 32'h300), "drop_check2");
    run_vec(mk(0, 0, 0, 32'h300, 1, 0, 0, 0, 12'h0, 32'h300), "drop_idle2");

    // Back-to-back read hit then write hit to another set.
    run_vec(mk(0, 1, 0, 32'h40, 1, 0, 0, 0, 12'h0, 32'h40), "b2b_idle1");
    run_vec(mk(0, 1, 0, 32'h40, 1, 0, 0, 0, HIT_RD, 32'h40), "b2b_hit1");
    run_vec(mk(0, 0, 1, 32'h60, 1, 0, 0, 0, 12'h0, 32'h60), "b2b_idle2");
    run_vec(mk(0, 0, 1, 32'h60, 1, 0, 0, 0, HIT_WR, 32'h60), "b2b_hit2");
    checks++;
    if (resp_last - resp_prev != 2) begin
      errors++;
      $display("FAIL b2b_spacing: gap=%0d cycles, required 2", resp_last - resp_prev);
    end
    run_vec(mk(0, 0, 0, 32'h60, 0, 0, 0, 0, 12'h0, 32'h60), "b2b_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
